// File: rtl/traffic_light_ctrl_if.sv
// Lamp/request bundle between the intersection controller and the board I/O wrapper.
// flash_req exists only when FLASH_MODE_EN is defined.
interface traffic_light_ctrl_if;
    logic       ped_req;
`ifdef FLASH_MODE_EN
    logic       flash_req;
`endif
    logic [2:0] ns_lamp;
    logic [2:0] ew_lamp;
    logic       walk;
    logic [2:0] phase;

`ifdef FLASH_MODE_EN
    modport master (output ped_req, output flash_req,
                    input  ns_lamp, input ew_lamp, input walk, input phase);
    modport slave  (input  ped_req, input  flash_req,
                    output ns_lamp, output ew_lamp, output walk, output phase);
`else
    modport master (output ped_req,
                    input  ns_lamp, input ew_lamp, input walk, input phase);
    modport slave  (input  ped_req,
                    output ns_lamp, output ew_lamp, output walk, output phase);
`endif
endinterface

// File: rtl/traffic_light_ctrl.sv
// Two-way NS/EW intersection controller with latched pedestrian walk and registered Moore lamps.
// Define FLASH_MODE_EN to add the flash_req input and the night-flash (blinking yellow) state.
module traffic_light_ctrl #(
    parameter int CNT_W      = 8,
    parameter int GREEN_T    = 6,
    parameter int YELLOW_T   = 3,
    parameter int RED_CLR    = 2,
    parameter int WALK_T     = 4,
    parameter int FLASH_HALF = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    traffic_light_ctrl_if.slave  bus
);
    if (GREEN_T < 1 || YELLOW_T < 1 || RED_CLR < 1 || WALK_T < 1 || FLASH_HALF < 1) begin : g_bad_param
        $error("traffic_light_ctrl: every phase length must be >= 1");
    end

    localparam logic [2:0] RED = 3'b100;
    localparam logic [2:0] YEL = 3'b010;
    localparam logic [2:0] GRN = 3'b001;

    localparam logic [CNT_W-1:0] GREEN_LAST  = CNT_W'(GREEN_T - 1);
    localparam logic [CNT_W-1:0] YELLOW_LAST = CNT_W'(YELLOW_T - 1);
    localparam logic [CNT_W-1:0] RED_LAST    = CNT_W'(RED_CLR - 1);
    localparam logic [CNT_W-1:0] WALK_LAST   = CNT_W'(WALK_T - 1);

    // 4-bit code leaves room for FLASH; unused codes fall back to IDLE.
    typedef enum logic [3:0] {
        IDLE      = 4'd0,
        ALL_RED_A = 4'd1,
        NS_GREEN  = 4'd2,
        NS_YELLOW = 4'd3,
        ALL_RED_B = 4'd4,
        EW_GREEN  = 4'd5,
        EW_YELLOW = 4'd6,
        PED_WALK  = 4'd7
`ifdef FLASH_MODE_EN
        , FLASH   = 4'd8
`endif
    } state_e;

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             ped_pend_q, ped_pend_d;
    logic [2:0]       ns_q, ns_d, ew_q, ew_d, phase_q, phase_d;
    logic             walk_q, walk_d;
`ifdef FLASH_MODE_EN
    localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(FLASH_HALF - 1);
    logic             blink_q, blink_d;
`endif

    always_comb begin
        state_d    = state_q;
        ped_pend_d = ped_pend_q | (bus.ped_req && state_q != PED_WALK);
        case (state_q)
            IDLE:      state_d = ALL_RED_A;
            // Request arriving on the exit cycle is honoured in the same decision.
            ALL_RED_A: if (cnt_q == RED_LAST)
                           state_d = (ped_pend_q || bus.ped_req) ? PED_WALK : NS_GREEN;
            NS_GREEN:  if (cnt_q == GREEN_LAST)  state_d = NS_YELLOW;
            NS_YELLOW: if (cnt_q == YELLOW_LAST) state_d = ALL_RED_B;
            ALL_RED_B: if (cnt_q == RED_LAST)    state_d = EW_GREEN;
            EW_GREEN:  if (cnt_q == GREEN_LAST)  state_d = EW_YELLOW;
            EW_YELLOW: if (cnt_q == YELLOW_LAST) state_d = ALL_RED_A;
            PED_WALK:  if (cnt_q == WALK_LAST)   state_d = ALL_RED_A;
`ifdef FLASH_MODE_EN
            FLASH:     state_d = ALL_RED_A;
`endif
            default:   state_d = IDLE;
        endcase
`ifdef FLASH_MODE_EN
        if (bus.flash_req) state_d = FLASH;
        if (state_d == FLASH || state_q == FLASH) ped_pend_d = 1'b0;
`endif
        if (state_d == PED_WALK) ped_pend_d = 1'b0;

        cnt_d = (state_d != state_q) ? '0 : cnt_q + CNT_W'(1);
`ifdef FLASH_MODE_EN
        blink_d = blink_q;
        if (state_d == FLASH && state_q != FLASH) begin
            blink_d = 1'b1;
        end else if (state_q == FLASH && cnt_q == HALF_LAST) begin
            blink_d = ~blink_q;
            cnt_d   = '0;
        end
`endif

        // Lamps decode the next state so they change on the same edge as the state.
        ns_d    = RED;
        ew_d    = RED;
        walk_d  = 1'b0;
        phase_d = state_d[2:0];
        case (state_d)
            NS_GREEN:  ns_d   = GRN;
            NS_YELLOW: ns_d   = YEL;
            EW_GREEN:  ew_d   = GRN;
            EW_YELLOW: ew_d   = YEL;
            PED_WALK:  walk_d = 1'b1;
`ifdef FLASH_MODE_EN
            FLASH: begin
                ns_d = {1'b0, blink_d, 1'b0};
                ew_d = {1'b0, blink_d, 1'b0};
            end
`endif
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            ped_pend_q <= 1'b0;
            ns_q       <= RED;
            ew_q       <= RED;
            walk_q     <= 1'b0;
            phase_q    <= 3'd0;
`ifdef FLASH_MODE_EN
            blink_q    <= 1'b0;
`endif
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            ped_pend_q <= ped_pend_d;
            ns_q       <= ns_d;
            ew_q       <= ew_d;
            walk_q     <= walk_d;
            phase_q    <= phase_d;
`ifdef FLASH_MODE_EN
            blink_q    <= blink_d;
`endif
        end
    end

    assign bus.ns_lamp = ns_q;
    assign bus.ew_lamp = ew_q;
    assign bus.walk    = walk_q;
    assign bus.phase   = phase_q;
endmodule
